overlay_marker_writer: RTL and testbench
========================================

# overlay_marker_writer

Draws feature markers into the double-buffered frame in SRAM. It takes keypoint coordinates from the detector back end and emits byte-masked `{mask,addr,data}` write requests into the SramArbiter W1 (overlay writer) port, beside the ImageBufferWriter on W0. Each keypoint becomes a 5-pixel "+" marker of a constant grey value, clipped at the frame edges.

## Interface
Parameters:
- `WIDTH`, 800, frame width in pixels
- `HEIGHT`, 600, frame height in pixels
- `FRAME1_BASE`, 18'd120000, word address of frame 1 (frame 0 base is 0)
- `MARKER_VALUE`, 8'hFF, pixel value written at every marker point

Ports:
- `clock` in 1: single clock (bg_clock domain).
- `reset` in 1: asynchronous, active-high.
- `frame_sel` in 1: target buffer (0 → base 0, 1 → `FRAME1_BASE`). Sampled on keypoint accept.
- `kp_x` in 10: keypoint column.
- `kp_y` in 10: keypoint row.
- `kp_valid` in 1: keypoint offered.
- `kp_ready` out 1: block can accept a keypoint.
- `dout` out 54: `{mask[3:0], addr[17:0], data[31:0]}`.
- `valid` out 1: `dout` holds a write request.
- `ready` in 1: arbiter accepts the write.
- `busy` out 1: a keypoint is in progress.
- `marker_count` out 16: in-range keypoints accepted; wraps.

## Operation
Pixel and word mapping:
- Pixel index = y·WIDTH + x (19 bits).
- Word address = base + index[18:2], 18 bits.
- Byte lane = index[1:0]. Mask bit i enables data[8i+7:8i], so the mask is one-hot on the lane.
- data = {4{MARKER_VALUE}}.

Marker offsets are emitted in a fixed order, k = 0..4: center (x,y), left (x−1,y), right (x+1,y), up (x,y−1), down (x,y+1).
- An offset is skipped when it falls outside the frame: x−1 when x=0, x+1 when x=WIDTH−1, y−1 when y=0, y+1 when y=HEIGHT−1.
- Coordinates never wrap to the other side of the frame.
- A skipped offset takes one cycle with no write issued.

State machine:
- **IDLE**
  - `kp_ready`=1.
  - On `kp_valid`&`kp_ready`: latch x, y and frame_sel.
  - If x≥WIDTH or y≥HEIGHT: go to DROP.
  - Otherwise: `marker_count`+1, k=0, go to EMIT.
- **DROP**
  - One cycle, no writes, count unchanged.
  - Then go to IDLE.
- **EMIT**
  - The output register loads offset k when (~`valid` | `ready`).
  - If offset k is valid: `valid`←1 and `dout`←request. If offset k is skipped: `valid`←0.
  - After offset 4 is loaded: go to DRAIN.
- **DRAIN**
  - Wait until `valid`=0, or `valid`&`ready`.
  - Then `valid`←0 and go to IDLE.

General rules:
- `kp_ready` is 1 only in IDLE. `busy` = state≠IDLE.
- While `valid`&~`ready`, `dout` and `valid` hold stable. `valid` never drops without a handshake.
- A change on `frame_sel` mid-marker does not affect that marker.

## Timing
- Reset values:
  - `valid`=0, `dout`=0, `kp_ready`=1, `busy`=0, `marker_count`=0, state=IDLE.
- Asynchronous reset:
  - Reset mid-marker aborts it. No further writes issue, and a pending `valid` clears immediately.
- Latency and throughput:
  - Keypoint accept at edge E. The first request is valid after edge E+1.
  - With `ready`=1, the 5 requests are valid after edges E+1..E+5.
  - `kp_ready` is high after edge E+6, so one keypoint takes 6 cycles minimum.
- Backpressure:
  - Each cycle of `ready`=0 with `valid`=1 adds one cycle.
- Simultaneous events:
  - A `kp_valid` arriving while busy is held off by `kp_ready`=0. It is not lost.

## Test plan
- **Interior marker.** frame_sel=0, kp (10,5), ready=1 → 5 consecutive requests, in order:
  - addr 1002 mask 0100
  - addr 1002 mask 0010
  - addr 1002 mask 1000
  - addr 802 mask 0100
  - addr 1202 mask 0100

  Every data = 32'hFFFFFFFF; `marker_count`=1.
- **Corner clipping.** kp (0,0) → exactly 3 writes: addr 0 mask 0001; addr 0 mask 0010; addr 200 mask 0001. Checks:
  - There are 2 idle cycles where left and up are skipped.
  - kp (799,599) → 3 writes: center, left, up only.
- **Frame select.** frame_sel=1, kp (10,5) → center addr 121002 mask 0100. Toggling frame_sel during emission leaves every remaining address based on 120000.
- **Backpressure.** kp (10,5), ready held 0 for 3 cycles on the first request → `dout` stays constant and `valid` stays 1. Then 5 handshakes total, no duplicates and no drops.
- **Out of range.** kp (800,0), then kp (5,600) → no valid pulses and `marker_count` unchanged. `kp_ready` returns 1 two cycles after each accept.
- **Reset mid-marker.** Assert reset after the 2nd handshake → `valid`=0 immediately, `marker_count`=0, `kp_ready`=1. After release, a new keypoint produces a full fresh sequence.

Source files
------------

// File: rtl/overlay_marker_writer.sv
// Turns detector keypoints into "+" shaped overlay markers, issuing one
// byte-masked SRAM write per in-frame marker point on the overlay write port.
module overlay_marker_writer #(
    parameter int          WIDTH        = 800,
    parameter int          HEIGHT       = 600,
    parameter logic [17:0] FRAME1_BASE  = 18'd120000,
    parameter logic [7:0]  MARKER_VALUE = 8'hFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_sel,
    input  logic [9:0]  kp_x,
    input  logic [9:0]  kp_y,
    input  logic        kp_valid,
    output logic        kp_ready,
    output logic [53:0] dout,
    output logic        valid,
    input  logic        ready,
    output logic        busy,
    output logic [15:0] marker_count
);

    localparam logic [9:0]  X_LIM   = 10'(WIDTH);
    localparam logic [9:0]  Y_LIM   = 10'(HEIGHT);
    localparam logic [9:0]  X_LAST  = 10'(WIDTH - 1);
    localparam logic [9:0]  Y_LAST  = 10'(HEIGHT - 1);
    localparam logic [18:0] WIDTH19 = 19'(WIDTH);

    typedef enum logic [1:0] {IDLE, DROP, EMIT, DRAIN} state_t;

    state_t      state;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic        sel_q;
    logic [2:0]  k;
    logic [9:0]  cx;
    logic [9:0]  cy;
    logic        skip;
    logic [18:0] pix_idx;
    logic [17:0] word_addr;

    function automatic logic [3:0] lane_mask(input logic [1:0] lane);
        lane_mask = 4'b0001 << lane;
    endfunction

    // Offset order: center, left, right, up, down; edge neighbours are skipped
    always_comb begin
        cx   = x_q;
        cy   = y_q;
        skip = 1'b0;
        case (k)
            3'd1: begin cx = x_q - 10'd1; skip = (x_q == 10'd0);  end
            3'd2: begin cx = x_q + 10'd1; skip = (x_q == X_LAST); end
            3'd3: begin cy = y_q - 10'd1; skip = (y_q == 10'd0);  end
            3'd4: begin cy = y_q + 10'd1; skip = (y_q == Y_LAST); end
            default: ;
        endcase
    end

    assign pix_idx   = {9'd0, cy} * WIDTH19 + {9'd0, cx};
    assign word_addr = (sel_q ? FRAME1_BASE : 18'd0) + {1'b0, pix_idx[18:2]};

    assign kp_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Keypoint capture: datapath only, qualified by the accept
    always_ff @(posedge clock) begin
        if (state == IDLE && kp_valid) begin
            x_q   <= kp_x;
            y_q   <= kp_y;
            sel_q <= frame_sel;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            k            <= 3'd0;
            valid        <= 1'b0;
            dout         <= '0;
            marker_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (kp_valid) begin
                        if (kp_x >= X_LIM || kp_y >= Y_LIM) begin
                            state <= DROP;
                        end else begin
                            marker_count <= marker_count + 16'd1;
                            k            <= 3'd0;
                            state        <= EMIT;
                        end
                    end
                end
                DROP: state <= IDLE;
                EMIT: begin
                    // Output register only advances once the held request is taken
                    if (!valid || ready) begin
                        valid <= !skip;
                        if (!skip)
                            dout <= {lane_mask(pix_idx[1:0]), word_addr, {4{MARKER_VALUE}}};
                        if (k == 3'd4)
                            state <= DRAIN;
                        else
                            k <= k + 3'd1;
                    end
                end
                DRAIN: begin
                    if (!valid || ready) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_overlay_marker_writer.sv
// Directed bench for overlay_marker_writer: table of keypoints with
// hand-computed write sequences plus backpressure, frame toggle and reset cases.
module tb_overlay_marker_writer;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_sel;
    logic [9:0]  kp_x;
    logic [9:0]  kp_y;
    logic        kp_valid;
    logic        kp_ready;
    logic [53:0] dout;
    logic        valid;
    logic        ready;
    logic        busy;
    logic [15:0] marker_count;

    overlay_marker_writer dut (
        .clock(clock), .reset(reset), .frame_sel(frame_sel),
        .kp_x(kp_x), .kp_y(kp_y), .kp_valid(kp_valid), .kp_ready(kp_ready),
        .dout(dout), .valid(valid), .ready(ready), .busy(busy),
        .marker_count(marker_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic            sel;
        logic [9:0]      x;
        logic [9:0]      y;
        logic [2:0]      n;
        logic [4:0]      vpat;
        logic [4:0][17:0] addr;
        logic [4:0][3:0]  mask;
        logic [15:0]     cnt;
    } vec_t;

    vec_t        tbl [6];
    logic [53:0] cap [$];
    int          napplied = 0;
    int          nmis = 0;

    // Every accepted write (valid & ready stable across the coming edge)
    always @(negedge clock) begin
        if (!reset && valid && ready) cap.push_back(dout);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        napplied++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one keypoint, then run until kp_ready returns (bounded)
    task automatic run_kp(input logic sel, input logic [9:0] x, input logic [9:0] y,
                          output int lat, output logic [4:0] vpat);
        cap.delete();
        frame_sel = sel; kp_x = x; kp_y = y; kp_valid = 1'b1;
        @(posedge clock); #1;
        kp_valid = 1'b0;
        lat = 0; vpat = '0;
        while (lat < 50) begin
            @(posedge clock); #1;
            lat++;
            if (lat <= 5) vpat[lat-1] = valid;
            if (kp_ready) break;
        end
    endtask

    task automatic check_writes(input string tag, input vec_t v);
        logic [53:0] w;
        chk({tag, "_nwrites"}, 64'(cap.size()), 64'(v.n));
        for (int j = 0; j < int'(v.n); j++) begin
            w = (j < cap.size()) ? cap[j] : '0;
            chk($sformatf("%s_addr%0d", tag, j), 64'(w[49:32]), 64'(v.addr[j]));
            chk($sformatf("%s_mask%0d", tag, j), 64'(w[53:50]), 64'(v.mask[j]));
            chk($sformatf("%s_data%0d", tag, j), 64'(w[31:0]), 64'(32'hFFFF_FFFF));
        end
        chk({tag, "_count"}, 64'(marker_count), 64'(v.cnt));
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int         lat;
        logic [4:0] vpat;
        run_kp(v.sel, v.x, v.y, lat, vpat);
        chk({tag, "_latency"}, 64'(lat), (v.n != 0) ? 64'd6 : 64'd1);
        chk({tag, "_vpattern"}, 64'(vpat), 64'(v.vpat));
        check_writes(tag, v);
    endtask

    initial begin
        int          lat;
        logic [4:0]  vpat;
        logic [53:0] held;
        int          guard;

        tbl[0] = '{sel:1'b0, x:10'd10, y:10'd5, n:3'd5, vpat:5'b11111,
                   addr:{18'd1202, 18'd802, 18'd1002, 18'd1002, 18'd1002},
                   mask:{4'b0100, 4'b0100, 4'b1000, 4'b0010, 4'b0100}, cnt:16'd1};
        tbl[1] = '{sel:1'b0, x:10'd0, y:10'd0, n:3'd3, vpat:5'b10101,
                   addr:{18'd0, 18'd0, 18'd200, 18'd0, 18'd0},
                   mask:{4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0001}, cnt:16'd2};
        tbl[2] = '{sel:1'b0, x:10'd799, y:10'd599, n:3'd3, vpat:5'b01011,
                   addr:{18'd0, 18'd0, 18'd119799, 18'd119999, 18'd119999},
                   mask:{4'b0000, 4'b0000, 4'b1000, 4'b0100, 4'b1000}, cnt:16'd3};
        tbl[3] = '{sel:1'b1, x:10'd10, y:10'd5, n:3'd5, vpat:5'b11111,
                   addr:{18'd121202, 18'd120802, 18'd121002, 18'd121002, 18'd121002},
                   mask:{4'b0100, 4'b0100, 4'b1000, 4'b0010, 4'b0100}, cnt:16'd4};
        tbl[4] = '{sel:1'b0, x:10'd800, y:10'd0, n:3'd0, vpat:5'b00000,
                   addr:'0, mask:'0, cnt:16'd4};
        tbl[5] = '{sel:1'b0, x:10'd5, y:10'd600, n:3'd0, vpat:5'b00000,
                   addr:'0, mask:'0, cnt:16'd4};

        reset = 1'b1; frame_sel = 1'b0; kp_x = '0; kp_y = '0; kp_valid = 1'b0; ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_dout", 64'(dout), 64'd0);
        chk("rst_kp_ready", 64'(kp_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_count", 64'(marker_count), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 6; i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

        // Backpressure on the first request
        cap.delete();
        ready = 1'b0; frame_sel = 1'b0; kp_x = 10'd10; kp_y = 10'd5; kp_valid = 1'b1;
        @(posedge clock); #1;
        kp_valid = 1'b0;
        @(posedge clock); #1;
        chk("bp_first_valid", 64'(valid), 64'd1);
        held = dout;
        for (int c = 0; c < 3; c++) begin
            @(posedge clock); #1;
            chk($sformatf("bp_hold_valid%0d", c), 64'(valid), 64'd1);
            chk($sformatf("bp_hold_dout%0d", c), 64'(dout), 64'(held));
        end
        ready = 1'b1;
        guard = 0;
        while (!kp_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        chk("bp_timeout", 64'(kp_ready), 64'd1);
        chk("bp_held_addr", 64'(held[49:32]), 64'd1002);
        check_writes("bp", '{sel:1'b0, x:10'd10, y:10'd5, n:3'd5, vpat:5'b11111,
                             addr:tbl[0].addr, mask:tbl[0].mask, cnt:16'd5});

        // frame_sel toggled mid-marker must not move the marker
        cap.delete();
        frame_sel = 1'b1; kp_x = 10'd10; kp_y = 10'd5; kp_valid = 1'b1;
        @(posedge clock); #1;
        kp_valid = 1'b0;
        @(posedge clock); #1;
        frame_sel = 1'b0;
        guard = 0;
        while (!kp_ready && guard < 50) begin
            @(posedge clock); #1;
            guard++;
        end
        check_writes("fsel", '{sel:1'b1, x:10'd10, y:10'd5, n:3'd5, vpat:5'b11111,
                               addr:tbl[3].addr, mask:tbl[3].mask, cnt:16'd6});

        // Reset after the second handshake aborts the marker
        cap.delete();
        frame_sel = 1'b0; kp_x = 10'd10; kp_y = 10'd5; kp_valid = 1'b1;
        @(posedge clock); #1;
        kp_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rm_pre_valid", 64'(valid), 64'd1);
        chk("rm_pre_writes", 64'(cap.size()), 64'd2);
        reset = 1'b1;
        #1;
        chk("rm_valid", 64'(valid), 64'd0);
        chk("rm_count", 64'(marker_count), 64'd0);
        chk("rm_kp_ready", 64'(kp_ready), 64'd1);
        chk("rm_busy", 64'(busy), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rm_no_writes", 64'(cap.size()), 64'd2);
        apply_vec("rm_fresh", tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", napplied, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
